// File: rtl/gate_truth_table_scanner.sv
// Self-test sequencer for the 8-input logic gate. It walks every input vector,
// records the gate response in a 256-entry truth table and counts the ones.
module gate_truth_table_scanner #(
   parameter int SETTLE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       abort,
   output logic [7:0] stim,
   input  logic       y_in,
   output logic       busy,
   output logic       done,
   output logic [8:0] ones_count,
   input  logic [7:0] rd_addr,
   output logic       rd_data,
   output logic [2:0] leds
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      APPLY  = 2'd1,
      SAMPLE = 2'd2,
      DONE   = 2'd3
   } state_t;

   localparam logic [7:0] CNT_LAST = 8'(SETTLE_CYCLES - 1);

   state_t       state;
   state_t       state_next;
   logic [7:0]   cnt;
   logic [7:0]   cnt_next;
   logic [7:0]   stim_next;
   logic [8:0]   ones_next;
   logic         led_y;
   logic         led_y_next;
   logic         wr_en;
   logic [255:0] tbl;

   // State and datapath registers; everything returns to zero on reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         stim       <= '0;
         ones_count <= '0;
         led_y      <= 1'b0;
      end else begin
         state      <= state_next;
         cnt        <= cnt_next;
         stim       <= stim_next;
         ones_count <= ones_next;
         led_y      <= led_y_next;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tbl <= '0;
      end else if (wr_en) begin
         tbl[stim] <= y_in;
      end
   end

   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      stim_next  = stim;
      ones_next  = ones_count;
      led_y_next = led_y;
      wr_en      = 1'b0;
      case (state)
         IDLE, DONE: begin
            // start has priority over abort outside a scan
            if (start) begin
               state_next = APPLY;
               cnt_next   = '0;
               stim_next  = '0;
               ones_next  = '0;
            end
         end
         APPLY: begin
            if (abort) begin
               state_next = IDLE;
               cnt_next   = '0;
               stim_next  = '0;
            end else begin
               cnt_next = cnt + 8'd1;
               if (cnt == CNT_LAST) begin
                  state_next = SAMPLE;
               end
            end
         end
         SAMPLE: begin
            // An abort landing on the sample cycle discards that vector.
            if (abort) begin
               state_next = IDLE;
               cnt_next   = '0;
               stim_next  = '0;
            end else begin
               wr_en      = 1'b1;
               led_y_next = y_in;
               ones_next  = ones_count + {8'd0, y_in};
               cnt_next   = '0;
               if (stim == 8'hFF) begin
                  state_next = DONE;
                  stim_next  = '0;
               end else begin
                  state_next = APPLY;
                  stim_next  = stim + 8'd1;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign busy    = (state == APPLY) || (state == SAMPLE);
   assign done    = (state == DONE);
   assign rd_data = tbl[rd_addr];
   assign leds    = {led_y, stim[1:0]};

endmodule
